// File: rtl/rvhazard_perfmon.sv
// rvhazard_perfmon: hazard-unit performance monitor with saturating event counters
// and an event FIFO whose overflow halts sampling until the next stop.
module rvhazard_perfmon #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             PCSrcE,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] fwd_cnt,
  output logic             evt_valid,
  output logic [19:0]      evt_data,
  input  logic             evt_ready,
  output logic             ovf,
  output logic [1:0]       state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] HALT = 2'b10;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] value,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, value} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  logic [19:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_next_s;
  logic [AW-1:0] rd_next_s;
  logic [AW:0]   count_r;
  logic [AW:0]   count_next_s;
  logic          prev_stall_r;
  logic [1:0]    state_next_s;
  logic [3:0]    evt_type_s;
  logic [15:0]   cyc16_s;
  logic [19:0]   evt_entry_s;
  logic [19:0]   head_next_s;
  logic [1:0]    fwd_inc_s;
  logic          run_s;
  logic          evt_fire_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic          lands_at_head_s;

  // Narrow builds zero-extend the cycle stamp into the 16-bit event field.
  if (CNT_W >= 16) begin : g_stamp_wide
    assign cyc16_s = cycle_cnt[15:0];
  end else begin : g_stamp_narrow
    assign cyc16_s = {{(16-CNT_W){1'b0}}, cycle_cnt};
  end

  assign run_s       = (state == RUN);
  assign fwd_inc_s   = {1'b0, (ForwardAE != 2'b00)} + {1'b0, (ForwardBE != 2'b00)};
  assign evt_entry_s = {cyc16_s, evt_type_s};
  assign evt_fire_s  = (evt_type_s != 4'h0);
  assign full_s      = (count_r == CNT_FULL);
  assign pop_s       = (count_r != CNT_ZERO) && evt_ready && !clear;
  assign push_s      = evt_fire_s && !clear && (!full_s || pop_s);
  assign drop_s      = evt_fire_s && !clear && full_s && !pop_s;
  // A push lands at the head when nothing older survives this edge.
  assign lands_at_head_s = push_s &&
                           ((count_r == CNT_ZERO) || ((count_r == CNT_ONE) && pop_s));

  // Classify this cycle's highest-priority event.
  always_comb begin
    evt_type_s = 4'h0;
    if (run_s) begin
      if (PCSrcE && !FlushD) begin
        evt_type_s = 4'h4;
      end else if (FlushD && PCSrcE) begin
        evt_type_s = 4'h2;
      end else if (FlushD) begin
        evt_type_s = 4'h3;
      end else if (StallD && !prev_stall_r) begin
        evt_type_s = 4'h1;
      end else begin
        evt_type_s = 4'h0;
      end
    end else begin
      evt_type_s = 4'h0;
    end
  end

  // Next FIFO pointers and occupancy.
  always_comb begin
    wr_next_s    = wr_ptr_r;
    rd_next_s    = rd_ptr_r;
    count_next_s = count_r;
    if (clear) begin
      wr_next_s    = {AW{1'b0}};
      rd_next_s    = {AW{1'b0}};
      count_next_s = CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_next_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_next_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_next_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_next_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + CNT_ONE;
        2'b01:   count_next_s = count_r - CNT_ONE;
        default: count_next_s = count_r;
      endcase
    end
  end

  // Head entry as it will be after this edge, so evt_data can be registered.
  always_comb begin
    head_next_s = 20'd0;
    if (count_next_s == CNT_ZERO) begin
      head_next_s = 20'd0;
    end else if (lands_at_head_s) begin
      head_next_s = evt_entry_s;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // FSM next state; stop beats both start and the overflow halt.
  always_comb begin
    state_next_s = state;
    case (state)
      IDLE: begin
        if (stop) begin
          state_next_s = IDLE;
        end else if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_next_s = IDLE;
        end else if (drop_s) begin
          state_next_s = HALT;
        end else begin
          state_next_s = RUN;
        end
      end
      HALT: begin
        if (stop) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HALT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FIFO storage; entries need no reset since the head output is gated by occupancy.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= evt_entry_s;
    end
  end

  // FIFO control and registered head/valid outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      count_r   <= CNT_ZERO;
      evt_valid <= 1'b0;
      evt_data  <= 20'd0;
    end else begin
      wr_ptr_r  <= wr_next_s;
      rd_ptr_r  <= rd_next_s;
      count_r   <= count_next_s;
      evt_valid <= (count_next_s != CNT_ZERO);
      evt_data  <= head_next_s;
    end
  end

  // Saturating event counters, advancing only while running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= {CNT_W{1'b0}};
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
      fwd_cnt   <= {CNT_W{1'b0}};
    end else if (clear) begin
      cycle_cnt <= {CNT_W{1'b0}};
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
      fwd_cnt   <= {CNT_W{1'b0}};
    end else if (run_s) begin
      cycle_cnt <= sat_add(cycle_cnt, 2'd1);
      stall_cnt <= sat_add(stall_cnt, {1'b0, StallD});
      flush_cnt <= sat_add(flush_cnt, {1'b0, FlushD});
      fwd_cnt   <= sat_add(fwd_cnt, fwd_inc_s);
    end else begin
      cycle_cnt <= cycle_cnt;
      stall_cnt <= stall_cnt;
      flush_cnt <= flush_cnt;
      fwd_cnt   <= fwd_cnt;
    end
  end

  // FSM state, sticky overflow and stall history (history tracks every cycle).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ovf          <= 1'b0;
      prev_stall_r <= 1'b0;
    end else begin
      state        <= state_next_s;
      prev_stall_r <= StallD;
      if (clear) begin
        ovf <= 1'b0;
      end else if (drop_s) begin
        ovf <= 1'b1;
      end else begin
        ovf <= ovf;
      end
    end
  end

endmodule

// File: doc/rvhazard_perfmon.md
RVHAZARD_PERFMON -- requirements
Module: rvhazard_perfmon

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, event FIFO entries (power of 2, at least 2).
REQ-002 Parameter CNT_W, default 32, width of every event counter.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  in  1  one-cycle pulse; IDLE->RUN.
REQ-006 stop  in  1  one-cycle pulse; RUN/HALT->IDLE.
REQ-007 clear  in  1  synchronous clear of counters, FIFO, ovf; state unchanged.
REQ-008 StallD  in  1  decode stall from hazard unit.
REQ-009 FlushD  in  1  decode flush from hazard unit.
REQ-010 PCSrcE  in  1  taken branch/jump in execute.
REQ-011 ForwardAE, ForwardBE  in  2 each  forwarding selects (2'b10 = from M, 2'b01 = from W).
REQ-012 cycle_cnt, stall_cnt, flush_cnt, fwd_cnt  out  CNT_W each  event counters.
REQ-013 evt_valid  out  1; evt_data  out  20  {cycle_cnt[15:0], type[3:0]}; evt_ready  in  1.
REQ-014 ovf  out  1  sticky FIFO-overflow flag; state  out  2  current FSM state.

Function
REQ-015 FSM states: IDLE=2'b00, RUN=2'b01, HALT=2'b10; 2'b11 is unreachable and decodes to IDLE on the next edge.
REQ-016 IDLE->RUN on start; RUN->HALT when an event is dropped on a full FIFO; RUN/HALT->IDLE on stop; stop has priority over start and over the overflow transition.
REQ-017 Counting occurs only in RUN; each counter saturates at all-ones, with no wrap.
REQ-018 cycle_cnt increments by 1 every RUN cycle.
REQ-019 stall_cnt increments on a RUN cycle with StallD=1.
REQ-020 flush_cnt increments on a RUN cycle with FlushD=1.
REQ-021 fwd_cnt increments by 1 per RUN cycle with ForwardAE!=0, and by a further 1 with ForwardBE!=0 (max +2 per cycle, still saturating).
REQ-022 Event types: 4'h1 stall rising edge (StallD=1, previous StallD=0); 4'h2 flush with PCSrcE=1; 4'h3 flush with PCSrcE=0; 4'h4 PCSrcE=1 with FlushD=0 (anomaly).
REQ-023 At most one event is pushed per cycle; priority order is 4'h4 > 4'h2 > 4'h3 > 4'h1.
REQ-024 An event is recorded with the pre-increment cycle_cnt[15:0] of that cycle, and is written into the FIFO at that clock edge.
REQ-025 evt_valid is high iff the FIFO is non-empty; evt_data presents the head entry, with no combinational path from inputs.
REQ-026 A pop occurs when evt_valid and evt_ready are both 1 at a clock edge.
REQ-027 Push and pop in the same cycle are both performed, including when the FIFO is full, because the pop frees the slot.
REQ-028 A push to a full FIFO with no pop is dropped, sets ovf=1, and moves the FSM RUN->HALT.
REQ-029 ovf stays set until clear or reset.
REQ-030 In HALT the counters freeze and no pushes occur; pops continue.
REQ-031 The previous-StallD register updates every cycle in all states, so the first RUN cycle with StallD high only counts as an edge if StallD was low on the prior cycle.
REQ-032 clear overrides same-cycle increments and pushes; a same-cycle pop is discarded.
REQ-033 FIFO pointers wrap modulo FIFO_DEPTH; occupancy is tracked as a log2(FIFO_DEPTH)+1-bit count.

Reset
REQ-034 While reset=1: state=IDLE, every counter=0, FIFO empty (evt_valid=0), evt_data=0, ovf=0, previous-StallD=0.
REQ-035 Reset asserted mid-RUN with a non-empty FIFO discards all entries immediately, without waiting for a clock edge.

Verification
REQ-036 start, then 10 RUN cycles with StallD high on cycles 3-5 -> cycle_cnt=10, stall_cnt=3, exactly one event with type 4'h1 and cycle field 3.
REQ-037 RUN with PCSrcE=1, FlushD=1, StallD rising in the same cycle -> exactly one event pushed, type 4'h2; flush_cnt=1, stall_cnt=1.
REQ-038 evt_ready=0 and 9 flush events with FIFO_DEPTH=8 -> 8 entries held, ovf=1, state=HALT, counters frozen; a following stop -> IDLE, ovf still 1.
REQ-039 FIFO full, with a push and a pop in the same cycle -> occupancy stays 8, ovf=0, the head advances, and the new entry lands at the tail.
REQ-040 With stall_cnt preloaded to all-ones (CNT_W=4 build at value 15), a further StallD in RUN -> stall_cnt stays at 15.
REQ-041 reset pulsed asynchronously between clock edges while in RUN with 3 queued entries -> evt_valid=0, all counters 0, state=IDLE before the next posedge.
